// File: rtl/ram_arbiter_if.sv
// Bundle of requester handshakes and RAM port signals shared by the arbiter
// and whatever sits around it (requesters plus RAM).
interface ram_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt0;
  logic                  gnt1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;
  logic                  rvalid0;
  logic                  rvalid1;
  logic                  ram_wr_enb;
  logic                  ram_rd_enb;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  busy;

  // Arbiter side
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
    output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
           ram_wr_enb, ram_rd_enb, ram_addr, ram_wdata, busy
  );

  // Requester / RAM environment side
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
    input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
           ram_wr_enb, ram_rd_enb, ram_addr, ram_wdata, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM with a
// one-cycle read latency; one access is in flight at a time.
module ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  ram_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, RETURN} state_t;

  state_t                state;
  logic                  cur_id;
  logic                  cur_we;
  logic                  last_gnt;
  logic                  gnt0_q;
  logic                  gnt1_q;
  logic                  rvalid0_q;
  logic                  rvalid1_q;
  logic                  wr_q;
  logic                  rd_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;

  logic                  win_id;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  // On a tie the requester that was not granted last wins
  always_comb begin
    win_id = 1'b0;
    if (bus.req0 && bus.req1)
      win_id = ~last_gnt;
    else if (bus.req1)
      win_id = 1'b1;
    win_we    = win_id ? bus.we1    : bus.we0;
    win_addr  = win_id ? bus.addr1  : bus.addr0;
    win_wdata = win_id ? bus.wdata1 : bus.wdata0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cur_id    <= 1'b0;
      cur_we    <= 1'b0;
      last_gnt  <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            cur_id   <= win_id;
            cur_we   <= win_we;
            last_gnt <= win_id;
            addr_q   <= win_addr;
            wdata_q  <= win_wdata;
            gnt0_q   <= ~win_id;
            gnt1_q   <= win_id;
            wr_q     <= win_we;
            rd_q     <= ~win_we;
            state    <= ACCESS;
          end
        end
        ACCESS: state <= cur_we ? IDLE : RDWAIT;
        RDWAIT: begin
          // RAM data is valid now, one cycle after the read enable
          if (cur_id) begin
            rdata1_q  <= bus.ram_rdata;
            rvalid1_q <= 1'b1;
          end else begin
            rdata0_q  <= bus.ram_rdata;
            rvalid0_q <= 1'b1;
          end
          state <= RETURN;
        end
        RETURN:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0       = gnt0_q;
  assign bus.gnt1       = gnt1_q;
  assign bus.rvalid0    = rvalid0_q;
  assign bus.rvalid1    = rvalid1_q;
  assign bus.rdata0     = rdata0_q;
  assign bus.rdata1     = rdata1_q;
  assign bus.ram_wr_enb = wr_q;
  assign bus.ram_rd_enb = rd_q;
  assign bus.ram_addr   = addr_q;
  assign bus.ram_wdata  = wdata_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a transaction-timeline model predicts every
// output each cycle, and literal checks pin the headline scenarios.
module tb_ram_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  bit cmp_en = 1'b0;

  logic [DW-1:0] ram_mem   [2**AW];
  logic [DW-1:0] model_mem [2**AW];

  // Behavioural RAM: write at the edge, registered read data
  always @(posedge clk) begin
    if (bus.ram_wr_enb) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_rd_enb) bus.ram_rdata <= ram_mem[bus.ram_addr];
  end

  typedef struct packed {
    logic          busy;
    logic          g0;
    logic          g1;
    logic          wr;
    logic          rd;
    logic          rv0;
    logic          rv1;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] data;
  } rec_t;

  rec_t          q[$];
  rec_t          cur;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata0;
  logic [DW-1:0] m_rdata1;
  logic          m_last;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t idle_rec();
    rec_t r;
    r       = '0;
    r.addr  = m_addr;
    r.wdata = m_wdata;
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    m_addr   = '0;
    m_wdata  = '0;
    m_rdata0 = '0;
    m_rdata1 = '0;
    m_last   = 1'b1;
    cur      = idle_rec();
  endtask

  // An accepted request expands into a list of per-cycle expectations:
  // one busy cycle for a write, three for a read (issue, wait, return).
  task automatic model_step();
    int            w;
    rec_t          r;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (!cur.busy && (bus.req0 || bus.req1)) begin
      if (bus.req0 && bus.req1) w = (m_last == 1'b1) ? 0 : 1;
      else                      w = bus.req1 ? 1 : 0;
      we      = (w == 1) ? bus.we1    : bus.we0;
      a       = (w == 1) ? bus.addr1  : bus.addr0;
      d       = (w == 1) ? bus.wdata1 : bus.wdata0;
      m_last  = (w == 1);
      m_addr  = a;
      m_wdata = d;
      r       = idle_rec();
      r.busy  = 1'b1;
      r.g0    = (w == 0);
      r.g1    = (w == 1);
      r.wr    = we;
      r.rd    = !we;
      q.push_back(r);
      if (we) begin
        model_mem[a] = d;
      end else begin
        r      = idle_rec();
        r.busy = 1'b1;
        q.push_back(r);
        r.rv0  = (w == 0);
        r.rv1  = (w == 1);
        r.data = model_mem[a];
        q.push_back(r);
      end
    end
    if (q.size() > 0) cur = q.pop_front();
    else              cur = idle_rec();
    if (cur.rv0) m_rdata0 = cur.data;
    if (cur.rv1) m_rdata1 = cur.data;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("busy",       bus.busy,       cur.busy);
      check_output("gnt0",       bus.gnt0,       cur.g0);
      check_output("gnt1",       bus.gnt1,       cur.g1);
      check_output("ram_wr_enb", bus.ram_wr_enb, cur.wr);
      check_output("ram_rd_enb", bus.ram_rd_enb, cur.rd);
      check_output("ram_addr",   bus.ram_addr,   cur.addr);
      check_output("ram_wdata",  bus.ram_wdata,  cur.wdata);
      check_output("rvalid0",    bus.rvalid0,    cur.rv0);
      check_output("rvalid1",    bus.rvalid1,    cur.rv1);
      check_output("rdata0",     bus.rdata0,     m_rdata0);
      check_output("rdata1",     bus.rdata1,     m_rdata1);
    end
  end

  task automatic apply_stimulus(input int id, input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata);
    if (id == 1) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end
  endtask

  // Returns the number of cycles until the grant and drops that request
  task automatic wait_grant(input int id, output int cycles);
    cycles = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((id == 1) ? bus.gnt1 : bus.gnt0) begin
        cycles = i;
        break;
      end
    end
    if (cycles == 0) check_output("grant_timeout", 32'd0, 32'd1);
    if (id == 1) bus.req1 = 1'b0;
    else         bus.req0 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check_output("rst_busy",   bus.busy,       0);
    check_output("rst_gnt0",   bus.gnt0,       0);
    check_output("rst_gnt1",   bus.gnt1,       0);
    check_output("rst_rv0",    bus.rvalid0,    0);
    check_output("rst_rv1",    bus.rvalid1,    0);
    check_output("rst_wr",     bus.ram_wr_enb, 0);
    check_output("rst_rd",     bus.ram_rd_enb, 0);
    check_output("rst_addr",   bus.ram_addr,   0);
    check_output("rst_wdata",  bus.ram_wdata,  0);
    check_output("rst_rdata0", bus.rdata0,     0);
    check_output("rst_rdata1", bus.rdata1,     0);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int c;
    int seq[$];
    int exp_seq[4];
    exp_seq = '{0, 1, 0, 1};
    for (int i = 0; i < 2**AW; i++) begin
      ram_mem[i]   = DW'(i * 7 + 1);
      model_mem[i] = DW'(i * 7 + 1);
    end
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    #3 do_reset();

    // Single write from requester 0
    apply_stimulus(0, 1'b1, 4'h3, 8'hA5);
    wait_grant(0, c);
    check_output("wr_latency", c, 1);
    check_output("wr_enb", bus.ram_wr_enb, 1);
    check_output("wr_rd_enb", bus.ram_rd_enb, 0);
    check_output("wr_addr", bus.ram_addr, 4'h3);
    check_output("wr_wdata", bus.ram_wdata, 8'hA5);
    @(negedge clk);

    // Single read from requester 1 of the same word
    apply_stimulus(1, 1'b0, 4'h3, 8'h5A);
    wait_grant(1, c);
    check_output("rd_latency", c, 1);
    check_output("rd_enb", bus.ram_rd_enb, 1);
    check_output("rd_addr", bus.ram_addr, 4'h3);
    repeat (2) @(negedge clk);
    check_output("rd_rvalid1", bus.rvalid1, 1);
    check_output("rd_rdata1", bus.rdata1, 8'hA5);
    check_output("rd_rdata0_kept", bus.rdata0, 8'h00);
    @(negedge clk);
    check_output("rd_rvalid1_pulse", bus.rvalid1, 0);
    check_output("rd_rdata1_hold", bus.rdata1, 8'hA5);

    // Write from 0, read from 1 submitted while busy
    apply_stimulus(0, 1'b1, 4'h5, 8'h3C);
    wait_grant(0, c);
    apply_stimulus(1, 1'b0, 4'h5, 8'h00);
    wait_grant(1, c);
    check_output("b2b_gap", c, 2);
    repeat (2) @(negedge clk);
    check_output("b2b_rvalid1", bus.rvalid1, 1);
    check_output("b2b_rdata1", bus.rdata1, 8'h3C);
    @(negedge clk);

    // Top address with all-ones data
    apply_stimulus(0, 1'b1, 4'hF, 8'hFF);
    wait_grant(0, c);
    check_output("bnd_wr_addr", bus.ram_addr, 4'hF);
    @(negedge clk);
    apply_stimulus(0, 1'b0, 4'hF, 8'h00);
    wait_grant(0, c);
    check_output("bnd_rd_addr", bus.ram_addr, 4'hF);
    repeat (2) @(negedge clk);
    check_output("bnd_rvalid0", bus.rvalid0, 1);
    check_output("bnd_rdata0", bus.rdata0, 8'hFF);
    check_output("bnd_rdata1_kept", bus.rdata1, 8'h3C);
    @(negedge clk);

    // Reset in the middle of a read
    apply_stimulus(1, 1'b0, 4'h3, 8'h00);
    wait_grant(1, c);
    @(negedge clk);
    check_output("mid_busy", bus.busy, 1);
    #2 do_reset();
    for (int i = 0; i < 4; i++) begin
      check_output("post_rst_rv0", bus.rvalid0, 0);
      check_output("post_rst_rv1", bus.rvalid1, 0);
      @(negedge clk);
    end
    apply_stimulus(1, 1'b0, 4'h3, 8'h00);
    wait_grant(1, c);
    check_output("post_rst_latency", c, 1);
    repeat (2) @(negedge clk);
    check_output("post_rst_rvalid1", bus.rvalid1, 1);
    check_output("post_rst_rdata1", bus.rdata1, 8'hA5);
    @(negedge clk);

    // Continuous tie after reset: grants must alternate starting with 0
    #2 do_reset();
    apply_stimulus(0, 1'b1, 4'h1, 8'h11);
    apply_stimulus(1, 1'b1, 4'h2, 8'h22);
    for (int i = 0; i < 16 && seq.size() < 4; i++) begin
      @(negedge clk);
      if (bus.gnt0 && bus.gnt1) check_output("tie_both", 32'd1, 32'd0);
      else if (bus.gnt0) seq.push_back(0);
      else if (bus.gnt1) seq.push_back(1);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    check_output("tie_count", seq.size(), 4);
    for (int i = 0; i < 4; i++)
      check_output("tie_order", (i < seq.size()) ? seq[i] : -1, exp_seq[i]);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
